// File: rtl/perf_counter_bank_if.sv
// -----------------------------------------------------------------------------
// perf_counter_bank_if
// Bundles the control, event and readout signals of perf_counter_bank.
//
//   count_en  : start counting (sampled in IDLE)
//   event_in  : one-cycle event pulses, one bit per channel
//   halt      : processor halt, freezes the bank
//   clear     : synchronous clear of counters, flags and state
//   rd_req    : readout request
//   rd_sel    : readout select (channels, then cycle counter)
//   rd_valid  : one-cycle readout strobe
//   rd_data   : selected counter value
//   rd_err    : rd_sel out of range, qualifies rd_valid
//   ovf       : sticky overflow flags, MSB = cycle counter
//   state     : IDLE=0, RUN=1, HALTED=2, TIMEOUT=3
//
// master drives the requests (system / bench side), slave is the counter bank.
// -----------------------------------------------------------------------------
interface perf_counter_bank_if #(
    parameter int NUM_EVENTS = 6,
    parameter int CNT_WIDTH  = 32
);
    logic                  count_en;
    logic [NUM_EVENTS-1:0] event_in;
    logic                  halt;
    logic                  clear;
    logic                  rd_req;
    logic [4:0]            rd_sel;
    logic                  rd_valid;
    logic [CNT_WIDTH-1:0]  rd_data;
    logic                  rd_err;
    logic [NUM_EVENTS:0]   ovf;
    logic [1:0]            state;

    modport master (
        output count_en, event_in, halt, clear, rd_req, rd_sel,
        input  rd_valid, rd_data, rd_err, ovf, state
    );

    modport slave (
        input  count_en, event_in, halt, clear, rd_req, rd_sel,
        output rd_valid, rd_data, rd_err, ovf, state
    );
endinterface

// File: rtl/perf_counter_bank.sv
// -----------------------------------------------------------------------------
// perf_counter_bank
// Bank of NUM_EVENTS event counters plus one free-running cycle counter,
// sequenced by a small IDLE/RUN/HALTED/TIMEOUT state machine, with a
// registered single-cycle readout port.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : perf_counter_bank_if.slave (control, events, readout, flags, state)
//
// Parameters:
//   NUM_EVENTS     : number of event channels (1..16)
//   CNT_WIDTH      : width of every counter (8..32)
//   SATURATE       : 1 = counters stick at all-ones, 0 = counters wrap
//   TIMEOUT_CYCLES : cycle count at which RUN is forced into TIMEOUT
// -----------------------------------------------------------------------------
module perf_counter_bank #(
    parameter int NUM_EVENTS     = 6,
    parameter int CNT_WIDTH      = 32,
    parameter int SATURATE       = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst,
    perf_counter_bank_if.slave bus
);

    localparam int NUM_CNT = NUM_EVENTS + 1;
    // The cycle counter sits just above the event channels in select space.
    localparam int CYC_IDX = NUM_EVENTS;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [4:0]           SEL_MAX = 5'(NUM_EVENTS);

    // A limit wider than the counter can never be matched, so timeout
    // detection is disabled outright instead of comparing truncated bits.
    localparam bit TMO_REACHABLE = ((64'(TIMEOUT_CYCLES) >> CNT_WIDTH) == 64'd0);
    localparam logic [CNT_WIDTH-1:0] TMO_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Counting happens only in RUN, and a clear on the same edge wins.
    logic w_counting;

    // Flattened views of all counters: current values and next values.
    logic [NUM_CNT*CNT_WIDTH-1:0] w_cnt_flat;
    logic [NUM_CNT*CNT_WIDTH-1:0] w_next_flat;
    logic [NUM_CNT-1:0]           w_ovf;

    logic                 w_cyc_hit;
    logic                 w_sel_err;
    logic [CNT_WIDTH-1:0] w_rd_mux;

    logic                 r_rd_valid;
    logic [CNT_WIDTH-1:0] r_rd_data;
    logic                 r_rd_err;

    assign w_counting = (r_state == ST_RUN) && !bus.clear;

    // -------------------------------------------------------------------------
    // Counter channels. Channel CYC_IDX is the cycle counter, incremented on
    // every counting edge; the others follow their event_in bit.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_ch
            logic [CNT_WIDTH-1:0] r_cnt;
            logic                 r_ovf;
            logic                 w_inc;
            logic [CNT_WIDTH-1:0] w_cnt_next;
            logic                 w_ovf_next;

            if (gi == CYC_IDX) begin : g_src_cyc
                assign w_inc = w_counting;
            end else begin : g_src_evt
                assign w_inc = w_counting & bus.event_in[gi];
            end

            always_comb begin
                w_cnt_next = r_cnt;
                w_ovf_next = r_ovf;
                if (bus.clear) begin
                    w_cnt_next = '0;
                    w_ovf_next = 1'b0;
                end else if (w_inc) begin
                    if (r_cnt == CNT_MAX) begin
                        // Overflow is flagged in both modes; only the
                        // resulting count differs.
                        w_ovf_next = 1'b1;
                        w_cnt_next = (SATURATE != 0) ? CNT_MAX : '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_WIDTH'(1);
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else begin
                    r_cnt <= w_cnt_next;
                    r_ovf <= w_ovf_next;
                end
            end

            assign w_cnt_flat[gi*CNT_WIDTH +: CNT_WIDTH]  = r_cnt;
            assign w_next_flat[gi*CNT_WIDTH +: CNT_WIDTH] = w_cnt_next;
            assign w_ovf[gi]                              = r_ovf;
        end
    endgenerate

    // Timeout compares the cycle counter's post-increment value, so the
    // edge that reaches the limit is still a counted edge.
    assign w_cyc_hit = TMO_REACHABLE &&
                       (w_next_flat[CYC_IDX*CNT_WIDTH +: CNT_WIDTH] == TMO_VAL);

    // -------------------------------------------------------------------------
    // State machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.clear) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.count_en) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // halt takes priority over a coincident timeout.
                    if (bus.halt) begin
                        w_state_next = ST_HALTED;
                    end else if (w_cyc_hit) begin
                        w_state_next = ST_TIMEOUT;
                    end
                end
                default: begin
                    // HALTED and TIMEOUT are left only by clear or rst.
                    w_state_next = r_state;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Readout. The mux reads the current register values, so a read on an
    // edge returns the count before that edge's increment or clear.
    // -------------------------------------------------------------------------
    assign w_sel_err = (bus.rd_sel > SEL_MAX);

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (bus.rd_sel == 5'(i)) begin
                w_rd_mux = w_cnt_flat[i*CNT_WIDTH +: CNT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_req;
            r_rd_data  <= bus.rd_req ? w_rd_mux : '0;
            r_rd_err   <= bus.rd_req & w_sel_err;
        end
    end

    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_err   = r_rd_err;
    assign bus.ovf      = w_ovf;
    assign bus.state    = r_state;

endmodule

// File: tb/tb_perf_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_perf_counter_bank
// Three instances share one stimulus stream:
//   0: 8-bit saturating, timeout out of reach
//   1: 8-bit wrapping,   timeout out of reach
//   2: 32-bit saturating, timeout at 50 cycles
// A behavioural model (integer counts, min/modulo arithmetic) predicts every
// instance's outputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_perf_counter_bank;

    localparam int NE = 6;
    localparam int ND = 3;
    localparam int S_IDLE = 0, S_RUN = 1, S_HALTED = 2, S_TIMEOUT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          count_en, halt, clear, rd_req;
    logic [NE-1:0] event_in;
    logic [4:0]    rd_sel;

    perf_counter_bank_if #(.NUM_EVENTS(NE), .CNT_WIDTH(8))  bus_s ();
    perf_counter_bank_if #(.NUM_EVENTS(NE), .CNT_WIDTH(8))  bus_w ();
    perf_counter_bank_if #(.NUM_EVENTS(NE), .CNT_WIDTH(32)) bus_t ();

    assign bus_s.count_en = count_en;  assign bus_w.count_en = count_en;  assign bus_t.count_en = count_en;
    assign bus_s.event_in = event_in;  assign bus_w.event_in = event_in;  assign bus_t.event_in = event_in;
    assign bus_s.halt     = halt;      assign bus_w.halt     = halt;      assign bus_t.halt     = halt;
    assign bus_s.clear    = clear;     assign bus_w.clear    = clear;     assign bus_t.clear    = clear;
    assign bus_s.rd_req   = rd_req;    assign bus_w.rd_req   = rd_req;    assign bus_t.rd_req   = rd_req;
    assign bus_s.rd_sel   = rd_sel;    assign bus_w.rd_sel   = rd_sel;    assign bus_t.rd_sel   = rd_sel;

    perf_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(8),  .SATURATE(1), .TIMEOUT_CYCLES(1000))
        dut_s (.clk(clk), .rst(rst), .bus(bus_s));
    perf_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(8),  .SATURATE(0), .TIMEOUT_CYCLES(1000))
        dut_w (.clk(clk), .rst(rst), .bus(bus_w));
    perf_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(32), .SATURATE(1), .TIMEOUT_CYCLES(50))
        dut_t (.clk(clk), .rst(rst), .bus(bus_t));

    logic [1:0]  o_state [ND];
    logic        o_valid [ND];
    logic [31:0] o_data  [ND];
    logic        o_err   [ND];
    logic [NE:0] o_ovf   [ND];

    assign o_state[0] = bus_s.state;  assign o_state[1] = bus_w.state;  assign o_state[2] = bus_t.state;
    assign o_valid[0] = bus_s.rd_valid; assign o_valid[1] = bus_w.rd_valid; assign o_valid[2] = bus_t.rd_valid;
    assign o_data[0]  = 32'(bus_s.rd_data); assign o_data[1] = 32'(bus_w.rd_data); assign o_data[2] = bus_t.rd_data;
    assign o_err[0]   = bus_s.rd_err; assign o_err[1] = bus_w.rd_err; assign o_err[2] = bus_t.rd_err;
    assign o_ovf[0]   = bus_s.ovf;    assign o_ovf[1] = bus_w.ovf;    assign o_ovf[2] = bus_t.ovf;

    // ---------------- reference model ----------------
    longint      m_max [ND];
    bit          m_sat [ND];
    longint      m_tmo [ND];
    int          m_st  [ND];
    longint      m_cnt [ND][NE+1];
    logic [NE:0] m_ovf [ND];
    bit          m_rv  [ND];
    longint      m_rd  [ND];
    bit          m_re  [ND];

    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        for (int k = 0; k < ND; k++) begin
            m_st[k] = S_IDLE;
            m_ovf[k] = '0;
            m_rv[k] = 0; m_rd[k] = 0; m_re[k] = 0;
            for (int i = 0; i <= NE; i++) m_cnt[k][i] = 0;
        end
    endtask

    // One rising edge worth of behaviour, using the inputs as currently driven.
    task automatic model_step();
        logic [NE:0] hits;
        hits = {1'b1, event_in};
        for (int k = 0; k < ND; k++) begin
            m_rv[k] = rd_req;
            m_re[k] = rd_req && (rd_sel > 5'(NE));
            m_rd[k] = (rd_req && rd_sel <= 5'(NE)) ? m_cnt[k][rd_sel] : 0;
            if (clear) begin
                for (int i = 0; i <= NE; i++) m_cnt[k][i] = 0;
                m_ovf[k] = '0;
                m_st[k] = S_IDLE;
            end else if (m_st[k] == S_IDLE) begin
                if (count_en) m_st[k] = S_RUN;
            end else if (m_st[k] == S_RUN) begin
                for (int i = 0; i <= NE; i++) begin
                    if (hits[i]) begin
                        longint nxt;
                        nxt = m_cnt[k][i] + 1;
                        if (nxt > m_max[k]) m_ovf[k][i] = 1'b1;
                        m_cnt[k][i] = m_sat[k] ? ((nxt > m_max[k]) ? m_max[k] : nxt)
                                               : (nxt % (m_max[k] + 1));
                    end
                end
                if (halt) m_st[k] = S_HALTED;
                else if (m_cnt[k][NE] == m_tmo[k]) m_st[k] = S_TIMEOUT;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        count_en = 0; event_in = '0; halt = 0; clear = 0; rd_req = 0; rd_sel = '0;
    endtask

    task automatic do_clear();
        clear = 1; step(); clear = 0;
    endtask

    task automatic start_run();
        do_clear();
        count_en = 1; step(); count_en = 0;
    endtask

    task automatic do_read(input logic [4:0] sel);
        rd_req = 1; rd_sel = sel; step(); rd_req = 0; rd_sel = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_state[k] !== 2'd0 || o_valid[k] !== 1'b0 || o_data[k] !== 32'd0 ||
                o_err[k] !== 1'b0 || o_ovf[k] !== '0) begin
                n_err++;
                $display("FAIL reset dut%0d: state=%0d valid=%0b data=%0d err=%0b ovf=%b, expected all zero",
                         k, o_state[k], o_valid[k], o_data[k], o_err[k], o_ovf[k]);
            end
        end
        // IDLE must not count even with events present.
        event_in = '1;
        repeat (3) step();
        event_in = '0;
        do_read(5'(NE));
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_state[k] !== 2'd0 || o_data[k] !== 32'd0 || o_valid[k] !== 1'b1) begin
                n_err++;
                $display("FAIL idle_hold dut%0d: state=%0d cyc=%0d valid=%0b, expected 0/0/1",
                         k, o_state[k], o_data[k], o_valid[k]);
            end
        end
    endtask

    task automatic test_basic();
        start_run();
        for (int c = 1; c <= 12; c++) begin
            event_in[0] = (c <= 10);
            halt = (c == 12);
            step();
        end
        halt = 0; event_in = '0;
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_state[k] !== 2'(S_HALTED)) begin
                n_err++;
                $display("FAIL basic_state dut%0d: got %0d expected %0d", k, o_state[k], S_HALTED);
            end
        end
        do_read(5'd0);
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_data[k] !== 32'd10 || o_data[k] !== 32'(m_rd[k])) begin
                n_err++;
                $display("FAIL basic_ch0 dut%0d: got %0d expected 10", k, o_data[k]);
            end
        end
        do_read(5'(NE));
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_data[k] !== 32'd12 || o_err[k] !== 1'b0) begin
                n_err++;
                $display("FAIL basic_cyc dut%0d: got %0d err=%0b expected 12 err=0", k, o_data[k], o_err[k]);
            end
        end
    endtask

    task automatic test_readout();
        start_run();
        for (int c = 1; c <= 4; c++) begin
            event_in = NE'($urandom);
            step();
        end
        event_in = '0;
        rd_req = 1; rd_sel = 5'(NE); step();
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_valid[k] !== 1'b1 || o_data[k] !== 32'd4 || o_err[k] !== 1'b0) begin
                n_err++;
                $display("FAIL read_cyc5 dut%0d: valid=%0b data=%0d err=%0b expected 1/4/0",
                         k, o_valid[k], o_data[k], o_err[k]);
            end
        end
        rd_sel = 5'd20; step();
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_valid[k] !== 1'b1 || o_data[k] !== 32'd0 || o_err[k] !== 1'b1) begin
                n_err++;
                $display("FAIL read_oor dut%0d: valid=%0b data=%0d err=%0b expected 1/0/1",
                         k, o_valid[k], o_data[k], o_err[k]);
            end
        end
        rd_req = 0; rd_sel = '0; step();
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_valid[k] !== 1'b0 || o_data[k] !== 32'd0 || o_err[k] !== 1'b0) begin
                n_err++;
                $display("FAIL read_idle dut%0d: valid=%0b data=%0d err=%0b expected 0/0/0",
                         k, o_valid[k], o_data[k], o_err[k]);
            end
        end
        // Back-to-back reads while counting.
        for (int c = 0; c < 10; c++) begin
            event_in = NE'($urandom);
            rd_req = 1; rd_sel = 5'($urandom_range(0, NE + 1));
            step();
            for (int k = 0; k < ND; k++) begin
                n_vec++;
                if (o_valid[k] !== 1'b1 || o_data[k] !== 32'(m_rd[k]) || o_err[k] !== m_re[k]) begin
                    n_err++;
                    $display("FAIL read_b2b dut%0d sel=%0d: data=%0d err=%0b expected %0d/%0b",
                             k, rd_sel, o_data[k], o_err[k], m_rd[k], m_re[k]);
                end
            end
        end
        rd_req = 0; event_in = '0;
    endtask

    task automatic test_saturate_wrap();
        int exp_ch1 [ND];
        int exp_cyc [ND];
        int exp_st  [ND];
        logic [NE:0] exp_ovf [ND];
        exp_ch1 = '{255, 44, 50};
        exp_cyc = '{255, 45, 50};
        exp_st  = '{S_HALTED, S_HALTED, S_TIMEOUT};
        exp_ovf = '{7'b1000010, 7'b1000010, 7'b0000000};
        start_run();
        event_in = 6'b000010;
        repeat (300) step();
        event_in = '0;
        halt = 1; step(); halt = 0;
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_state[k] !== 2'(exp_st[k]) || o_ovf[k] !== exp_ovf[k] || o_ovf[k] !== m_ovf[k]) begin
                n_err++;
                $display("FAIL sat_flags dut%0d: state=%0d ovf=%b expected %0d/%b",
                         k, o_state[k], o_ovf[k], exp_st[k], exp_ovf[k]);
            end
        end
        do_read(5'd1);
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_data[k] !== 32'(exp_ch1[k])) begin
                n_err++;
                $display("FAIL sat_ch1 dut%0d: got %0d expected %0d", k, o_data[k], exp_ch1[k]);
            end
        end
        do_read(5'(NE));
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_data[k] !== 32'(exp_cyc[k])) begin
                n_err++;
                $display("FAIL sat_cyc dut%0d: got %0d expected %0d", k, o_data[k], exp_cyc[k]);
            end
        end
    endtask

    task automatic test_timeout();
        start_run();
        repeat (49) step();
        n_vec++;
        if (o_state[2] !== 2'(S_RUN)) begin
            n_err++;
            $display("FAIL tmo_before: state=%0d expected %0d", o_state[2], S_RUN);
        end
        event_in = '1; step(); event_in = '0;
        n_vec++;
        if (o_state[2] !== 2'(S_TIMEOUT)) begin
            n_err++;
            $display("FAIL tmo_fire: state=%0d expected %0d", o_state[2], S_TIMEOUT);
        end
        event_in = '1; repeat (3) step(); event_in = '0;
        do_read(5'(NE));
        n_vec++;
        if (o_data[2] !== 32'd50) begin
            n_err++;
            $display("FAIL tmo_cyc: got %0d expected 50", o_data[2]);
        end
        do_read(5'd3);
        n_vec++;
        if (o_data[2] !== 32'd1) begin
            n_err++;
            $display("FAIL tmo_ch3_frozen: got %0d expected 1", o_data[2]);
        end
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (o_state[k] !== 2'(S_RUN) || o_data[k] !== 32'(m_rd[k])) begin
                n_err++;
                $display("FAIL tmo_unreach dut%0d: state=%0d ch3=%0d expected %0d/%0d",
                         k, o_state[k], o_data[k], S_RUN, m_rd[k]);
            end
        end
        start_run();
        repeat (49) step();
        halt = 1; step(); halt = 0;
        n_vec++;
        if (o_state[2] !== 2'(S_HALTED)) begin
            n_err++;
            $display("FAIL tmo_halt_wins: state=%0d expected %0d", o_state[2], S_HALTED);
        end
    endtask

    task automatic test_clear_halt();
        start_run();
        event_in = 6'b000001;
        repeat (7) step();
        event_in = '0;
        repeat (2) step();
        clear = 1; halt = 1; rd_req = 1; rd_sel = 5'd0; event_in = '1;
        step();
        clear = 0; halt = 0; rd_req = 0; event_in = '0;
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_state[k] !== 2'(S_IDLE) || o_ovf[k] !== '0 || o_valid[k] !== 1'b1 || o_data[k] !== 32'd7) begin
                n_err++;
                $display("FAIL clr_halt dut%0d: state=%0d ovf=%b valid=%0b data=%0d expected 0/0/1/7",
                         k, o_state[k], o_ovf[k], o_valid[k], o_data[k]);
            end
        end
        do_read(5'd0);
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_data[k] !== 32'd0) begin
                n_err++;
                $display("FAIL clr_ch0 dut%0d: got %0d expected 0", k, o_data[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        start_run();
        event_in = 6'b000100;
        repeat (9) step();
        event_in = '0;
        rd_req = 1; rd_sel = 5'd2;
        #2 rst = 1;
        model_reset();
        #1;
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_state[k] !== 2'd0 || o_valid[k] !== 1'b0 || o_ovf[k] !== '0) begin
                n_err++;
                $display("FAIL arst_now dut%0d: state=%0d valid=%0b ovf=%b expected 0/0/0",
                         k, o_state[k], o_valid[k], o_ovf[k]);
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_valid[k] !== 1'b0 || o_data[k] !== 32'd0) begin
                n_err++;
                $display("FAIL arst_noread dut%0d: valid=%0b data=%0d expected 0/0", k, o_valid[k], o_data[k]);
            end
        end
        @(negedge clk);
        rst = 0; rd_req = 0; rd_sel = '0;
        event_in = 6'b000100;
        repeat (3) step();
        event_in = '0;
        do_read(5'd2);
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (o_data[k] !== 32'd0 || o_state[k] !== 2'(S_IDLE)) begin
                n_err++;
                $display("FAIL arst_ch2 dut%0d: ch2=%0d state=%0d expected 0/0", k, o_data[k], o_state[k]);
            end
        end
    endtask

    task automatic test_random();
        do_clear();
        for (int c = 0; c < 1500; c++) begin
            clear    = ($urandom_range(0, 299) == 0);
            count_en = ($urandom_range(0, 3) == 0);
            halt     = ($urandom_range(0, 399) == 0);
            event_in = NE'($urandom);
            rd_req   = $urandom_range(0, 1) == 1;
            rd_sel   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, NE));
            step();
            for (int k = 0; k < ND; k++) begin
                n_vec++;
                if (o_state[k] !== 2'(m_st[k]) || o_valid[k] !== m_rv[k] || o_data[k] !== 32'(m_rd[k]) ||
                    o_err[k] !== m_re[k] || o_ovf[k] !== m_ovf[k]) begin
                    n_err++;
                    $display("FAIL random c%0d dut%0d: st=%0d v=%0b d=%0d e=%0b ovf=%b expected st=%0d v=%0b d=%0d e=%0b ovf=%b",
                             c, k, o_state[k], o_valid[k], o_data[k], o_err[k], o_ovf[k],
                             m_st[k], m_rv[k], m_rd[k], m_re[k], m_ovf[k]);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        m_max = '{255, 255, 64'hFFFF_FFFF};
        m_sat = '{1'b1, 1'b0, 1'b1};
        m_tmo = '{1000, 1000, 50};
        idle_inputs();
        rst = 1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;

        test_reset();
        test_basic();
        test_readout();
        test_saturate_wrap();
        test_timeout();
        test_clear_halt();
        test_async_reset();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_EVENTS, default 6, number of event channels (1..16).
REQ-002 Parameter CNT_WIDTH, default 32, width of every counter (8..32).
REQ-003 Parameter SATURATE, default 1, 1 = counters saturate at all-ones, 0 = counters wrap.
REQ-004 Parameter TIMEOUT_CYCLES, default 100000, cycle-count limit that forces TIMEOUT.
REQ-005 Port clk  input  1  single clock; all state changes on rising edge.
REQ-006 Port rst  input  1  asynchronous, active-high reset.
REQ-007 Port count_en  input  1  start counting; sampled in IDLE only.
REQ-008 Port event_in  input  NUM_EVENTS  one-cycle event pulses; bit i increments channel i.
REQ-009 Port halt  input  1  processor halt; freezes all counters.
REQ-010 Port clear  input  1  synchronous clear of counters, flags and state.
REQ-011 Port rd_req  input  1  readout request.
REQ-012 Port rd_sel  input  5  readout select: 0..NUM_EVENTS-1 = event channel, NUM_EVENTS = cycle counter.
REQ-013 Port rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-014 Port rd_data  output  CNT_WIDTH  selected counter value.
REQ-015 Port rd_err  output  1  rd_sel out of range, qualifies rd_valid.
REQ-016 Port ovf  output  NUM_EVENTS+1  sticky overflow flags; bit NUM_EVENTS = cycle counter.
REQ-017 Port state  output  2  IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.

Function
REQ-018 State IDLE: no counter changes; IDLE->RUN on the first edge with count_en=1.
REQ-019 State RUN: each edge, cycle counter +1 and channel i +1 for each asserted event_in[i].
REQ-020 RUN->HALTED on the edge where halt=1; that edge's events and cycle are counted.
REQ-021 RUN->TIMEOUT on the edge where the cycle counter's post-increment value equals TIMEOUT_CYCLES; that edge's events are counted.
REQ-022 halt and timeout on the same edge: HALTED wins.
REQ-023 HALTED and TIMEOUT are terminal: counters hold, event_in/halt/count_en ignored; exit only via clear or rst.
REQ-024 clear=1 in any state: next edge all counters 0, ovf 0, state IDLE; clear overrides halt, timeout and events on that edge.
REQ-025 Increment of a counter at all-ones: SATURATE=1 holds all-ones; SATURATE=0 wraps to 0; either mode sets the matching ovf bit, which stays set until clear or rst.
REQ-026 TIMEOUT_CYCLES larger than 2^CNT_WIDTH-1: timeout never fires; cycle counter follows REQ-025.
REQ-027 Readout: rd_req=1 at edge N yields rd_valid=1 for exactly one cycle after edge N, with rd_data = the selected counter value before edge N's increment.
REQ-028 Readout is allowed in every state and back-to-back every cycle; it never stalls counting.
REQ-029 rd_sel > NUM_EVENTS: rd_data=0, rd_err=1 with rd_valid; otherwise rd_err=0.
REQ-030 rd_req and clear on the same edge: the read returns the pre-clear value.
REQ-031 rd_valid=0 implies rd_data=0 and rd_err=0.

Reset
REQ-032 rst=1 asynchronously forces state=IDLE, all counters=0, ovf=0, rd_valid=0, rd_data=0, rd_err=0.
REQ-033 rst asserted mid-RUN discards all counts; after release the block waits in IDLE for count_en.
REQ-034 Outputs are registered; no combinational path from inputs to outputs.

Verification
REQ-035 Reset, count_en for 1 cycle, event_in[0]=1 for 10 cycles, halt on cycle 12 -> state=HALTED, ch0=10, cycle counter=12.
REQ-036 CNT_WIDTH=8, SATURATE=1, event_in[1] held 300 cycles -> ch1=255, ovf[1]=1; SATURATE=0 -> ch1=44, ovf[1]=1.
REQ-037 TIMEOUT_CYCLES=50, no halt -> state=TIMEOUT after cycle 50, cycle counter=50; halt on cycle 50 -> state=HALTED instead.
REQ-038 rd_req with rd_sel=NUM_EVENTS on cycle 5 of RUN -> next cycle rd_valid=1, rd_data=4; rd_sel=20 -> rd_valid=1, rd_err=1, rd_data=0.
REQ-039 clear and halt on the same edge with ch0=7 -> state=IDLE, ch0=0, ovf=0; concurrent read of ch0 returns 7.
REQ-040 rst pulsed asynchronously mid-RUN with ch2=9 -> immediately ch2=0, state=IDLE, no rd_valid.
